// File: rtl/code2421_seq_checker.sv
`default_nettype none
// ============================================================================
//  Module      : code2421_seq_checker
//  Description : Receive-side checker for a 4-bit 2421 (Aiken) decade
//                counter. Decodes each sampled code word, flags illegal
//                codes, tracks the 0..9 successor sequence with an
//                IDLE/ACQ/LOCKED FSM and keeps error and decade counters.
//  Ports       : clk       - system clock, rising edge
//                rst       - asynchronous active-low reset
//                in2421    - 2421 code word from the counter
//                in_vld    - sample in2421 this cycle
//                clr       - synchronous clear of err_cnt / wrap_cnt
//                digit     - decoded digit of the last legal sample
//                digit_vld - pulse: digit updated
//                code_err  - pulse: illegal code sampled
//                seq_err   - pulse: legal code broke sequence while LOCKED
//                locked    - FSM is in LOCKED
//                err_cnt   - saturating count of code_err + seq_err events
//                wrap_cnt  - count of 9->0 steps seen while LOCKED
//  Revision    : 1.0 - initial release
// ============================================================================
module code2421_seq_checker #(
  parameter int LOCK_N = 2,
  parameter int ERR_W  = 8,
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        in2421,
  input  logic              in_vld,
  input  logic              clr,
  output logic [3:0]        digit,
  output logic              digit_vld,
  output logic              code_err,
  output logic              seq_err,
  output logic              locked,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [WRAP_W-1:0] wrap_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] prev, prev_nxt;
  logic [3:0] good, good_nxt;
  logic [3:0] digit_nxt;
  logic       digit_vld_nxt, code_err_nxt, seq_err_nxt;
  logic       err_inc, wrap_inc;

  logic [3:0] dec;
  logic       legal;
  logic [3:0] expect_dig;
  logic       match;
  logic [4:0] good_inc;

  // 2421 decode; anything outside the ten Aiken words is illegal
  always_comb begin
    dec   = 4'd0;
    legal = 1'b1;
    case (in2421)
      4'b0000: dec = 4'd0;
      4'b0001: dec = 4'd1;
      4'b0010: dec = 4'd2;
      4'b0011: dec = 4'd3;
      4'b0100: dec = 4'd4;
      4'b1011: dec = 4'd5;
      4'b1100: dec = 4'd6;
      4'b1101: dec = 4'd7;
      4'b1110: dec = 4'd8;
      4'b1111: dec = 4'd9;
      default: legal = 1'b0;
    endcase
  end

  assign expect_dig = (prev == 4'd9) ? 4'd0 : prev + 4'd1;
  assign match      = (dec == expect_dig);
  assign good_inc   = {1'b0, good} + 5'd1;

  always_comb begin
    state_nxt     = state;
    prev_nxt      = prev;
    good_nxt      = good;
    digit_nxt     = digit;
    digit_vld_nxt = 1'b0;
    code_err_nxt  = 1'b0;
    seq_err_nxt   = 1'b0;
    err_inc       = 1'b0;
    wrap_inc      = 1'b0;

    if (in_vld) begin
      if (!legal) begin
        code_err_nxt = 1'b1;
        err_inc      = 1'b1;
        state_nxt    = IDLE;
        good_nxt     = 4'd0;
      end else begin
        digit_nxt     = dec;
        digit_vld_nxt = 1'b1;
        prev_nxt      = dec;
        case (state)
          IDLE: begin
            state_nxt = ACQ;
            good_nxt  = 4'd0;
          end
          ACQ: begin
            if (match) begin
              good_nxt = good_inc[3:0];
              if (good_inc >= 5'(LOCK_N)) state_nxt = LOCKED;
            end else begin
              good_nxt = 4'd0;
            end
          end
          LOCKED: begin
            if (match) begin
              // only a genuine 9->0 step closes a decade
              wrap_inc = (prev == 4'd9);
            end else begin
              seq_err_nxt = 1'b1;
              err_inc     = 1'b1;
              state_nxt   = ACQ;
              good_nxt    = 4'd0;
            end
          end
          default: begin
            state_nxt = IDLE;
            good_nxt  = 4'd0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      prev      <= 4'd0;
      good      <= 4'd0;
      digit     <= 4'd0;
      digit_vld <= 1'b0;
      code_err  <= 1'b0;
      seq_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      prev      <= prev_nxt;
      good      <= good_nxt;
      digit     <= digit_nxt;
      digit_vld <= digit_vld_nxt;
      code_err  <= code_err_nxt;
      seq_err   <= seq_err_nxt;
    end
  end

  // clr wins over a same-cycle increment
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt  <= '0;
      wrap_cnt <= '0;
    end else if (clr) begin
      err_cnt  <= '0;
      wrap_cnt <= '0;
    end else begin
      if (err_inc && !(&err_cnt)) err_cnt <= err_cnt + ERR_W'(1);
      if (wrap_inc) wrap_cnt <= wrap_cnt + WRAP_W'(1);
    end
  end

  assign locked = (state == LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_code2421_seq_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_code2421_seq_checker
//  Description : Self-checking bench for code2421_seq_checker. A behavioural
//                model (arithmetic 2421 weights, run-length of correct
//                successors) is compared against the DUT every cycle, and
//                hand-computed literal expectations pin key points.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_code2421_seq_checker;

  localparam int LOCK_N = 2;
  localparam int ERR_W  = 2;
  localparam int WRAP_W = 8;
  localparam int ERR_MAX = (1 << ERR_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [3:0]        in2421 = 4'd0;
  logic              in_vld = 1'b0;
  logic              clr = 1'b0;
  logic [3:0]        digit;
  logic              digit_vld, code_err, seq_err, locked;
  logic [ERR_W-1:0]  err_cnt;
  logic [WRAP_W-1:0] wrap_cnt;

  code2421_seq_checker #(.LOCK_N(LOCK_N), .ERR_W(ERR_W), .WRAP_W(WRAP_W)) dut (
    .clk(clk), .rst(rst), .in2421(in2421), .in_vld(in_vld), .clr(clr),
    .digit(digit), .digit_vld(digit_vld), .code_err(code_err),
    .seq_err(seq_err), .locked(locked), .err_cnt(err_cnt), .wrap_cnt(wrap_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Aiken code words for digits 0..9
  logic [3:0] enc [10] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
                           4'b1011, 4'b1100, 4'b1101, 4'b1110, 4'b1111};

  // ---------------- behavioural model ----------------
  int m_prev;   // -1: no legal reference sample yet
  int m_run;    // consecutive correct successors since the reference
  int m_digit, m_dv, m_ce, m_se, m_err, m_wrap;

  // weights 2,4,2,1; a word is legal only when its top bit agrees with value>=5
  function automatic int dec2421(input logic [3:0] c);
    int v;
    v = 2 * c[3] + 4 * c[2] + 2 * c[1] + c[0];
    if ((c[3] == 1'b1) != (v >= 5)) return -1;
    return v;
  endfunction

  function automatic int m_locked();
    return (m_prev >= 0 && m_run >= LOCK_N) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_prev = -1; m_run = 0;
    m_digit = 0; m_dv = 0; m_ce = 0; m_se = 0; m_err = 0; m_wrap = 0;
  endtask

  task automatic model_step(input logic v, input logic [3:0] c, input logic cl);
    int d, err_ev, wrap_ev, was_locked;
    err_ev = 0; wrap_ev = 0;
    m_dv = 0; m_ce = 0; m_se = 0;
    if (v) begin
      d = dec2421(c);
      was_locked = m_locked();
      if (d < 0) begin
        m_ce = 1; err_ev = 1; m_prev = -1; m_run = 0;
      end else begin
        m_dv = 1; m_digit = d;
        if (m_prev < 0) m_run = 0;
        else if (d == (m_prev + 1) % 10) begin
          if (was_locked == 1 && m_prev == 9) wrap_ev = 1;
          m_run++;
        end else begin
          if (was_locked == 1) begin m_se = 1; err_ev = 1; end
          m_run = 0;
        end
        m_prev = d;
      end
    end
    if (cl) begin
      m_err = 0; m_wrap = 0;
    end else begin
      m_err  = (m_err + err_ev > ERR_MAX) ? ERR_MAX : m_err + err_ev;
      m_wrap = (m_wrap + wrap_ev) % (1 << WRAP_W);
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("cyc_digit",     int'(digit),     m_digit);
    chk("cyc_digit_vld", int'(digit_vld), m_dv);
    chk("cyc_code_err",  int'(code_err),  m_ce);
    chk("cyc_seq_err",   int'(seq_err),   m_se);
    chk("cyc_locked",    int'(locked),    m_locked());
    chk("cyc_err_cnt",   int'(err_cnt),   m_err);
    chk("cyc_wrap_cnt",  int'(wrap_cnt),  m_wrap);
  end

  // inputs change 1 time unit after the edge; outputs are read there too
  task automatic drive(input logic v, input logic [3:0] c, input logic cl);
    in_vld = v; in2421 = c; clr = cl;
    @(posedge clk);
    if (rst) model_step(v, c, cl);
    #1;
  endtask

  task automatic feed(input int from, input int n);
    for (int i = 0; i < n; i++) drive(1'b1, enc[(from + i) % 10], 1'b0);
  endtask

  initial begin
    model_reset();
    // reset held with active-looking input
    rst = 1'b0;
    for (int i = 0; i < 3; i++) drive(1'b1, 4'b1111, 1'b0);
    chk("rst_digit", int'(digit), 0);
    chk("rst_dv", int'(digit_vld), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_err", int'(err_cnt), 0);
    chk("rst_wrap", int'(wrap_cnt), 0);
    chk("rst_code_err", int'(code_err), 0);
    rst = 1'b1;

    // lock on 0,1,2 then run through a decade
    feed(0, 2);
    chk("acq_not_locked", int'(locked), 0);
    feed(2, 1);
    chk("lock_locked", int'(locked), 1);
    chk("lock_digit", int'(digit), 2);
    chk("lock_err", int'(err_cnt), 0);
    feed(3, 8);
    chk("wrap1", int'(wrap_cnt), 1);
    chk("wrap1_digit", int'(digit), 0);

    // illegal code while locked
    drive(1'b1, 4'b0110, 1'b0);
    chk("ill_code_err", int'(code_err), 1);
    chk("ill_err", int'(err_cnt), 1);
    chk("ill_locked", int'(locked), 0);
    chk("ill_digit_hold", int'(digit), 0);
    feed(3, 3);
    chk("relock", int'(locked), 1);
    chk("relock_digit", int'(digit), 5);

    // sequence break at digit 3
    feed(6, 8);
    chk("pre_break_wrap", int'(wrap_cnt), 2);
    chk("pre_break_digit", int'(digit), 3);
    drive(1'b1, 4'b1110, 1'b0);
    chk("brk_seq_err", int'(seq_err), 1);
    chk("brk_err", int'(err_cnt), 2);
    chk("brk_locked", int'(locked), 0);
    chk("brk_digit", int'(digit), 8);
    feed(9, 2);
    chk("brk_relock", int'(locked), 1);
    // the 9->0 step that completes acquisition is not yet observed while LOCKED
    chk("brk_wrap_hold", int'(wrap_cnt), 2);
    feed(1, 10);
    chk("wrap3", int'(wrap_cnt), 3);

    // clear, then saturation with ERR_W=2
    drive(1'b0, 4'd0, 1'b1);
    chk("clr_err", int'(err_cnt), 0);
    chk("clr_wrap", int'(wrap_cnt), 0);
    drive(1'b1, 4'b0101, 1'b0);
    drive(1'b1, 4'b0111, 1'b0);
    drive(1'b1, 4'b1000, 1'b0);
    drive(1'b1, 4'b1001, 1'b0);
    chk("sat_err", int'(err_cnt), 3);
    drive(1'b1, 4'b1010, 1'b1);
    chk("clr_prio_err", int'(err_cnt), 0);
    chk("clr_prio_code_err", int'(code_err), 1);

    // gaps keep lock
    feed(4, 3);
    chk("gap_locked0", int'(locked), 1);
    feed(7, 1);
    for (int i = 0; i < 5; i++) drive(1'b0, 4'b0101, 1'b0);
    chk("gap_locked", int'(locked), 1);
    chk("gap_digit", int'(digit), 7);
    chk("gap_dv", int'(digit_vld), 0);
    feed(8, 1);
    chk("gap_next_locked", int'(locked), 1);
    chk("gap_next_digit", int'(digit), 8);
    // repeated value is a break
    feed(8, 1);
    chk("rep_seq_err", int'(seq_err), 1);
    chk("rep_locked", int'(locked), 0);
    chk("rep_err", int'(err_cnt), 1);
    feed(9, 2);
    chk("rep_relock", int'(locked), 1);
    // clr colliding with a wrap increment
    feed(1, 9);
    chk("pre_clr_wrap", int'(wrap_cnt), 0);
    drive(1'b1, enc[0], 1'b1);
    chk("clr_wrap_prio", int'(wrap_cnt), 0);
    chk("clr_wrap_locked", int'(locked), 1);

    // asynchronous reset while locked
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("async_locked", int'(locked), 0);
    chk("async_digit", int'(digit), 0);
    drive(1'b1, enc[1], 1'b0);
    drive(1'b1, enc[2], 1'b0);
    rst = 1'b1;
    feed(1, 2);
    chk("post_rst_2", int'(locked), 0);
    feed(3, 1);
    chk("post_rst_3", int'(locked), 1);
    chk("post_rst_digit", int'(digit), 3);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
